regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters: ALU (0), multdiv (1) and load unit (2). It arbitrates round-robin with a valid/ready handshake and registers the winning write into the regfile write-port signals. It also keeps a pending-write scoreboard (busy mask) that the decode stage uses for RAW hazard stalls.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register address width; the register count is 2**ADDR_WIDTH

Ports:
clock  input  1  system clock, rising-edge
ctrl_reset  input  1  asynchronous, active-low reset
ctrl_stall  input  1  when 1, no grants are issued this cycle
req_valid  input  NUM_REQ  per-requester write request
req_reg  input  NUM_REQ*ADDR_WIDTH  destination registers; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  write data, sliced the same way
req_ready  output  NUM_REQ  one-hot grant; 0 or 1 bit set
issue_valid  input  1  decode issues an instruction that has a destination register
issue_reg  input  ADDR_WIDTH  destination register of the issued instruction
ctrl_writeEnable  output  1  to the regfile write port
ctrl_writeReg  output  ADDR_WIDTH  to the regfile write port
data_writeReg  output  DATA_WIDTH  to the regfile write port
busy_mask  output  2**ADDR_WIDTH  bit r = 1 means a write to r is pending
idle  output  1  busy_mask == 0 and ctrl_writeEnable == 0

Behaviour:
- Reset: asserting ctrl_reset low takes effect immediately, with no clock edge.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy_mask=0, rr_ptr=0, idle=1.
  - req_ready=0 while reset is asserted.
  - Reset mid-operation drops any registered write and clears all busy bits.
- Grant (combinational):
  - If ctrl_stall=0, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … wrapping mod NUM_REQ.
  - req_ready = grant. If ctrl_stall=1 or no request is valid, req_ready=0.
  - req_ready never depends on req_reg or req_data.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] & req_ready[i].
  - A requester holds req_valid, req_reg and req_data stable until it is granted.
  - Exactly one transfer per cycle at most.
- Pointer: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Output stage (1-cycle latency):
  - On the transfer edge, ctrl_writeReg and data_writeReg load the granted slices.
  - ctrl_writeEnable <= 1 only if the granted reg != 0. A write to r0 is accepted (handshake completes) but never enabled.
  - With no transfer, ctrl_writeEnable <= 0. ctrl_writeReg and data_writeReg hold their last values.
  - The regfile captures on the edge that ends the ctrl_writeEnable cycle. There is no backpressure from the regfile.
- Scoreboard:
  - Set: at an edge with issue_valid=1 and issue_reg != 0, busy[issue_reg] <= 1.
  - Clear: at an edge with ctrl_writeEnable=1, busy[ctrl_writeReg] <= 0.
  - Set and clear of the same reg on the same edge: set wins, so the bit stays 1.
  - Set of a reg that is already busy: no change (no counting). Decode must not issue to a busy reg.
  - busy_mask[0] is hard-wired 0.
- Fairness: with all NUM_REQ continuously valid and no stall, each requester is granted exactly once every NUM_REQ cycles.

Test Plan:
- Single request: reset, then req_valid=3'b001, req_reg[0]=5, req_data[0]=0xDEADBEEF for 1 cycle. Expect req_ready=3'b001 that cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; the cycle after, ctrl_writeEnable=0.
- Round-robin: hold req_valid=3'b111 for 6 cycles. Expect req_ready sequence 001,010,100,001,010,100 and writes emerge 1 cycle later in the same order.
- Register 0: grant a request with req_reg=0, data=0x1234. Expect req_ready=1 and ctrl_writeEnable stays 0; busy_mask unchanged.
- Scoreboard: issue_valid with issue_reg=7 → busy_mask[7]=1 and idle=0. Then requester 1 writes r7 → busy[7] clears on the edge ending the write cycle, and idle returns to 1. Also drive issue_reg=7 on that same clear edge → busy[7] stays 1.
- Stall: hold req_valid=3'b110 with ctrl_stall=1 for 3 cycles. Expect req_ready=0 and ctrl_writeEnable=0 throughout. On release, requester 1 is granted first (rr_ptr=0 search reaches 1).
- Async reset mid-operation: assert ctrl_reset=0 between edges while ctrl_writeEnable=1 and busy_mask=0x80. Expect all outputs 0 before the next edge. After release, the first grant starts the search from requester 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between writeback
// requesters, with a registered write stage and a pending-write busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                             clock,
  input  logic                             ctrl_reset,
  input  logic                             ctrl_stall,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_reg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_reg,
  output logic                             ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]            data_writeReg,
  output logic [(2**ADDR_WIDTH)-1:0]       busy_mask,
  output logic                             idle
);

  localparam int PTR_W    = $clog2(NUM_REQ);
  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [PTR_W-1:0]      rrPtr;
  logic [NUM_REQ-1:0]    grant_p0;
  logic [PTR_W-1:0]      grantIdx_p0;
  logic [ADDR_WIDTH-1:0] grantReg_p0;
  logic [DATA_WIDTH-1:0] grantData_p0;
  logic                  vld_p0;
  logic [PTR_W-1:0]      rrPtrNext;
  logic [NUM_REGS-1:0]   busyNext;

  // Stage p0: combinational grant, searching from rrPtr with wrap-around.
  always_comb begin
    grant_p0     = '0;
    grantIdx_p0  = '0;
    grantReg_p0  = '0;
    grantData_p0 = '0;
    vld_p0       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!vld_p0 && req_valid[i] && (i == (int'(rrPtr) + k) % NUM_REQ)) begin
          vld_p0       = 1'b1;
          grant_p0[i]  = 1'b1;
          grantIdx_p0  = PTR_W'(i);
          grantReg_p0  = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
          grantData_p0 = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    if (ctrl_stall || !ctrl_reset) begin
      grant_p0 = '0;
      vld_p0   = 1'b0;
    end
  end

  assign req_ready = grant_p0;

  always_comb begin
    rrPtrNext = rrPtr;
    if (vld_p0) begin
      rrPtrNext = (grantIdx_p0 == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx_p0 + PTR_W'(1);
    end
  end

  // Set beats clear when decode re-issues the register being retired.
  always_comb begin
    busyNext = busy_mask;
    if (ctrl_writeEnable) busyNext[ctrl_writeReg] = 1'b0;
    if (issue_valid && issue_reg != '0) busyNext[issue_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Stage p1: registered write port and scoreboard.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      rrPtr            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      busy_mask        <= '0;
    end else begin
      rrPtr            <= rrPtrNext;
      busy_mask        <= busyNext;
      ctrl_writeEnable <= vld_p0 && (grantReg_p0 != '0);
      if (vld_p0) begin
        ctrl_writeReg <= grantReg_p0;
        data_writeReg <= grantData_p0;
      end
    end
  end

  assign idle = (busy_mask == '0) && !ctrl_writeEnable;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every
// cycle plus literal expectations for each scenario.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock;
  logic            ctrl_reset;
  logic            ctrl_stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_reg;
  logic            ctrl_writeEnable;
  logic [AW-1:0]   ctrl_writeReg;
  logic [DW-1:0]   data_writeReg;
  logic [31:0]     busy_mask;
  logic            idle;

  int tests = 0;
  int fails = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_stall(ctrl_stall),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_reg(issue_reg),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .busy_mask(busy_mask), .idle(idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: pointer, write-port contents, busy set.
  int            mPtr  = 0;
  logic          mWe   = 1'b0;
  logic [AW-1:0] mReg  = '0;
  logic [DW-1:0] mData = '0;
  logic [31:0]   mBusy = '0;

  function automatic int pick();
    if (!ctrl_reset || ctrl_stall) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mPtr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      mPtr = 0; mWe = 1'b0; mReg = '0; mData = '0; mBusy = '0;
    end else begin
      int g;
      logic [31:0] nb;
      nb = mBusy;
      if (mWe) nb[mReg] = 1'b0;
      if (issue_valid && issue_reg != 0) nb[issue_reg] = 1'b1;
      nb[0] = 1'b0;
      mBusy = nb;
      g = pick();
      if (g >= 0) begin
        mReg  = req_reg[g*AW +: AW];
        mData = req_data[g*DW +: DW];
        mWe   = (mReg != 0);
        mPtr  = (g + 1) % N;
      end else begin
        mWe = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    int g;
    g = pick();
    chk("m_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("m_we", ctrl_writeEnable, mWe);
    chk("m_wreg", ctrl_writeReg, mReg);
    chk("m_wdata", data_writeReg, mData);
    chk("m_busy", busy_mask, mBusy);
    chk("m_idle", idle, (mBusy == 0) && !mWe);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic setReq(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    ctrl_reset = 1'b1; ctrl_stall = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
    issue_valid = 1'b0; issue_reg = '0;
    #1 ctrl_reset = 1'b0;
    req_valid = 3'b111;
    repeat (2) cyc();
    #1;
    chk("rst_ready", req_ready, 3'b000);
    chk("rst_we", ctrl_writeEnable, 1'b0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_idle", idle, 1'b1);
    req_valid = '0;
    ctrl_reset = 1'b1;
    cyc();

    // Single request
    setReq(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1 chk("single_ready", req_ready, 3'b001);
    cyc(); req_valid = '0;
    #1;
    chk("single_we", ctrl_writeEnable, 1'b1);
    chk("single_reg", ctrl_writeReg, 5'd5);
    chk("single_data", data_writeReg, 32'hDEADBEEF);
    cyc();
    #1 chk("single_we_drop", ctrl_writeEnable, 1'b0);

    // Register 0 write from requester 2 (pointer moves back to 0)
    setReq(2, 5'd0, 32'h1234);
    req_valid = 3'b100;
    #1 chk("r0_ready", req_ready, 3'b100);
    cyc(); req_valid = '0;
    #1;
    chk("r0_we", ctrl_writeEnable, 1'b0);
    chk("r0_busy", busy_mask, 32'h0);

    // Round-robin with all three requesting
    setReq(0, 5'd1, 32'hA0); setReq(1, 5'd2, 32'hA1); setReq(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      logic [2:0] expRdy;
      expRdy = 3'b001 << (k % 3);
      #1 chk("rr_ready", req_ready, expRdy);
      cyc();
      #1;
      chk("rr_we", ctrl_writeEnable, 1'b1);
      chk("rr_reg", ctrl_writeReg, 5'(k % 3 + 1));
      chk("rr_data", data_writeReg, 32'hA0 + 32'(k % 3));
    end
    req_valid = '0;
    cyc();

    // Scoreboard set then clear through requester 1
    issue_valid = 1'b1; issue_reg = 5'd7;
    cyc(); issue_valid = 1'b0;
    #1;
    chk("sb_set", busy_mask, 32'h80);
    chk("sb_idle0", idle, 1'b0);
    setReq(1, 5'd7, 32'h77);
    req_valid = 3'b010;
    #1 chk("sb_ready", req_ready, 3'b010);
    cyc(); req_valid = '0;
    #1;
    chk("sb_we", ctrl_writeEnable, 1'b1);
    chk("sb_busy_during", busy_mask, 32'h80);
    cyc();
    #1;
    chk("sb_clear", busy_mask, 32'h0);
    chk("sb_idle1", idle, 1'b1);

    // Set and clear of r7 on the same edge: set wins
    issue_valid = 1'b1; issue_reg = 5'd7;
    cyc(); issue_valid = 1'b0;
    setReq(1, 5'd7, 32'h88);
    req_valid = 3'b010;
    cyc(); req_valid = '0;
    issue_valid = 1'b1; issue_reg = 5'd7;
    cyc(); issue_valid = 1'b0;
    #1 chk("sb_setwins", busy_mask, 32'h80);
    req_valid = 3'b010;
    cyc(); req_valid = '0;
    cyc();
    #1 chk("sb_final_idle", idle, 1'b1);

    // Move pointer to 0, then stall with requesters 1 and 2 pending
    setReq(2, 5'd0, 32'h0);
    req_valid = 3'b100;
    cyc(); req_valid = '0;
    ctrl_stall = 1'b1;
    setReq(1, 5'd9, 32'h99); setReq(2, 5'd10, 32'hAA);
    req_valid = 3'b110;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_ready", req_ready, 3'b000);
      cyc();
      #1 chk("stall_we", ctrl_writeEnable, 1'b0);
    end
    ctrl_stall = 1'b0;
    #1 chk("unstall_ready", req_ready, 3'b010);
    cyc(); req_valid = 3'b100;
    #1;
    chk("unstall_reg", ctrl_writeReg, 5'd9);
    chk("unstall_next", req_ready, 3'b100);
    cyc(); req_valid = '0;
    cyc();

    // Async reset while a write is in flight and r7 busy
    issue_valid = 1'b1; issue_reg = 5'd7;
    cyc(); issue_valid = 1'b0;
    setReq(0, 5'd3, 32'h5);
    req_valid = 3'b001;
    cyc(); req_valid = '0;
    #1;
    chk("ar_pre_we", ctrl_writeEnable, 1'b1);
    chk("ar_pre_busy", busy_mask, 32'h80);
    ctrl_reset = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("ar_we", ctrl_writeEnable, 1'b0);
    chk("ar_reg", ctrl_writeReg, 5'd0);
    chk("ar_data", data_writeReg, 32'h0);
    chk("ar_busy", busy_mask, 32'h0);
    chk("ar_idle", idle, 1'b1);
    chk("ar_ready", req_ready, 3'b000);
    cyc();
    ctrl_reset = 1'b1;
    #1 chk("ar_first_grant", req_ready, 3'b001);
    cyc(); req_valid = '0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
